// File: rtl/uart_fifo_top_if.sv
// ----------------------------------------------------------------------------
// uart_fifo_top_if
//  User-side byte streams of the UART: the RX FIFO head (valid/ready pop) and
//  the TX request (valid/ready push).
//  master : user logic  - consumes rx_*, drives tx_data/tx_valid and rx_ready
//  slave  : the UART    - drives rx_data/rx_valid and tx_ready
//  Signals:
//    rx_data_o  [DATA_BITS]  FIFO head (first-word-fall-through)
//    rx_valid_o              head is valid
//    rx_ready_i              pop the head when rx_valid_o is 1
//    tx_data_i  [DATA_BITS]  byte to send
//    tx_valid_i              send request
//    tx_ready_o              transmitter can accept a byte
// ----------------------------------------------------------------------------
interface uart_fifo_top_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic [DATA_BITS-1:0] tx_data_i;
    logic                 tx_valid_i;
    logic                 tx_ready_o;

    modport master (
        input  rx_data_o, rx_valid_o, tx_ready_o,
        output rx_ready_i, tx_data_i, tx_valid_i
    );

    modport slave (
        output rx_data_o, rx_valid_o, tx_ready_o,
        input  rx_ready_i, tx_data_i, tx_valid_i
    );
endinterface

// File: rtl/uart_fifo_top.sv
// ----------------------------------------------------------------------------
// uart_fifo_top
//  UART with 16x-oversampled receiver (parity and stop-bit checks), an RX FIFO,
//  a valid/ready transmitter and an echo mode that loops received bytes back.
//  Ports:
//    CLK_i, RSTn_i        clock, asynchronous active-low reset
//    RS232_RX_i           serial input (asynchronous)
//    RS232_TX_o           serial output, idle high
//    echo_en_i            1: FIFO head feeds TX, user streams held idle
//    usr                  user byte streams (uart_fifo_top_if.slave)
//    frame_err_o          1-cycle pulse, stop bit sampled low
//    parity_err_o         1-cycle pulse, parity mismatch
//    overflow_o           sticky, good byte arrived with FIFO full
//    LED_o                last good received byte, zero-extended
// ----------------------------------------------------------------------------
module uart_fifo_top #(
    parameter int DIV        = 78,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            CLK_i,
    input  logic            RSTn_i,
    input  logic            RS232_RX_i,
    output logic            RS232_TX_o,
    input  logic            echo_en_i,
    uart_fifo_top_if.slave  usr,
    output logic            frame_err_o,
    output logic            parity_err_o,
    output logic            overflow_o,
    output logic [7:0]      LED_o
);
    localparam int         CW        = $clog2(DIV);
    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    // ---------------- oversample tick ----------------
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    assign tick       = (tick_cnt_q == CW'(DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) tick_cnt_q <= '0;
        else         tick_cnt_q <= tick_cnt_d;
    end

    // ---------------- RX synchroniser + FSM ----------------
    logic                 rx_meta_q, rx_sync_q;
    rx_state_t            rx_state_q;
    logic [3:0]           rx_ph_q;
    logic [2:0]           rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_q;
    logic                 frame_err_q, parity_err_q, rx_good_q;
    logic                 rx_bit_end, par_bad;

    assign rx_bit_end = tick && (rx_ph_q == 4'd15);
    assign par_bad    = (PARITY != 0) && (rx_par_q != par_of(rx_shift_q));

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_ph_q      <= '0;
            rx_bit_q     <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            rx_good_q    <= 1'b0;
        end else begin
            rx_meta_q    <= RS232_RX_i;
            rx_sync_q    <= rx_meta_q;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            rx_good_q    <= 1'b0;
            case (rx_state_q)
                RX_IDLE: if (!rx_sync_q) begin
                    rx_state_q <= RX_START;
                    rx_ph_q    <= '0;
                end
                // mid start bit: a line already back high was a glitch
                RX_START: if (tick) begin
                    if (rx_ph_q == 4'd7) begin
                        rx_ph_q    <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_ph_q <= rx_ph_q + 4'd1;
                    end
                end
                RX_DATA: if (tick) begin
                    rx_ph_q <= rx_ph_q + 4'd1;
                    if (rx_bit_end) begin
                        if (rx_bit_q == LAST_BIT) rx_state_q <= (PARITY != 0) ? RX_PAR : RX_STOP;
                        else                      rx_bit_q   <= rx_bit_q + 3'd1;
                    end
                end
                RX_PAR: if (tick) begin
                    rx_ph_q <= rx_ph_q + 4'd1;
                    if (rx_bit_end) rx_state_q <= RX_STOP;
                end
                // verdict is registered; the push happens the cycle after
                RX_STOP: if (tick) begin
                    rx_ph_q <= rx_ph_q + 4'd1;
                    if (rx_bit_end) begin
                        rx_state_q   <= RX_IDLE;
                        frame_err_q  <= !rx_sync_q;
                        parity_err_q <= par_bad;
                        rx_good_q    <= rx_sync_q && !par_bad;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_i) begin
        if (rx_state_q == RX_DATA && rx_bit_end) rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_state_q == RX_PAR && rx_bit_end)  rx_par_q   <= rx_sync_q;
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 empty, full, push, pop, echo_pop, user_pop;
    logic                 overflow_q;
    logic [7:0]           led_q;
    logic [DATA_BITS-1:0] head;
    tx_state_t            tx_state_q;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign echo_pop = echo_en_i && (tx_state_q == TX_IDLE) && !empty;
    assign user_pop = !echo_en_i && usr.rx_ready_i && !empty;
    assign pop      = echo_pop || user_pop;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign push     = rx_good_q && (!full || pop);

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            led_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (rx_good_q && full && !pop) overflow_q <= 1'b1;
            if (rx_good_q) led_q <= 8'(rx_shift_q);
        end
    end

    always_ff @(posedge CLK_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end

    // ---------------- TX FSM ----------------
    logic                 txd_q;
    logic [4:0]           tx_cnt_q;
    logic [2:0]           tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q, tx_in;
    logic                 tx_par_q;
    logic                 tx_accept, tx_bit_end;

    assign tx_in      = echo_en_i ? head : usr.tx_data_i;
    assign tx_accept  = (tx_state_q == TX_IDLE) && (echo_en_i ? !empty : usr.tx_valid_i);
    assign tx_bit_end = tick && (tx_cnt_q == 5'd15);

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            tx_state_q <= TX_IDLE;
            txd_q      <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: if (tx_accept) tx_state_q <= TX_WAIT;
                // align the start bit to the tick grid
                TX_WAIT: if (tick) begin
                    txd_q      <= 1'b0;
                    tx_cnt_q   <= '0;
                    tx_state_q <= TX_START;
                end
                TX_START: if (tick) begin
                    tx_cnt_q <= tx_bit_end ? 5'd0 : tx_cnt_q + 5'd1;
                    if (tx_bit_end) begin
                        txd_q      <= tx_shift_q[0];
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: if (tick) begin
                    tx_cnt_q <= tx_bit_end ? 5'd0 : tx_cnt_q + 5'd1;
                    if (tx_bit_end) begin
                        if (tx_bit_q != LAST_BIT) begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            txd_q    <= tx_shift_q[1];
                        end else if (PARITY != 0) begin
                            txd_q      <= tx_par_q;
                            tx_state_q <= TX_PAR;
                        end else begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end
                    end
                end
                TX_PAR: if (tick) begin
                    tx_cnt_q <= tx_bit_end ? 5'd0 : tx_cnt_q + 5'd1;
                    if (tx_bit_end) begin
                        txd_q      <= 1'b1;
                        tx_state_q <= TX_STOP;
                    end
                end
                TX_STOP: if (tick) begin
                    if (tx_cnt_q == STOP_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 5'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_i) begin
        if (tx_accept) begin
            tx_shift_q <= tx_in;
            tx_par_q   <= par_of(tx_in);
        end else if (tx_state_q == TX_DATA && tx_bit_end) begin
            tx_shift_q <= tx_shift_q >> 1;
        end
    end

    // ---------------- outputs ----------------
    assign RS232_TX_o     = txd_q;
    assign usr.rx_data_o  = head;
    assign usr.rx_valid_o = !empty && !echo_en_i;
    assign usr.tx_ready_o = (tx_state_q == TX_IDLE) && !echo_en_i;
    assign frame_err_o    = frame_err_q;
    assign parity_err_o   = parity_err_q;
    assign overflow_o     = overflow_q;
    assign LED_o          = led_q;
endmodule
